// File: rtl/qam_tx_pkg.sv
// Shared types and helpers for the M-QAM transmitter: FSM states, Gray decode, index-to-level mapping.
package qam_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } qam_state_e;

    // Derived values for the default 16-QAM build; the core derives its own from BPS.
    localparam int BPS_DEF   = 4;
    localparam int L         = 2 ** (BPS_DEF / 2);
    localparam int LVL_W     = BPS_DEF / 2 + 1;

    // Helpers work on the widest index (256-QAM); narrower indices are zero-extended.
    localparam int IDX_MAX_W = 4;
    localparam int LVL_MAX_W = IDX_MAX_W + 1;

    function automatic logic [IDX_MAX_W-1:0] gray2bin(input logic [IDX_MAX_W-1:0] g);
        logic [IDX_MAX_W-1:0] b;
        b[IDX_MAX_W-1] = g[IDX_MAX_W-1];
        for (int k = IDX_MAX_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Level = 2k - (2^half - 1), symmetric odd levels around zero.
    function automatic logic signed [LVL_MAX_W-1:0] idx_to_level(input logic [IDX_MAX_W-1:0] k,
                                                                 input int half);
        int v;
        v = 2 * int'(k) - ((1 << half) - 1);
        return LVL_MAX_W'(v);
    endfunction

endpackage

// File: rtl/qam_nco_lut.sv
// Phase accumulator with a full-wave sine ROM read twice (sine and quarter-wave-shifted cosine).
module qam_nco_lut #(
    parameter int PHASE_W = 16,
    parameter int FCW     = 4096,
    parameter int LUT_AW  = 6,
    parameter int AMP_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    advance,
    output logic signed [AMP_W-1:0] sin_q,
    output logic signed [AMP_W-1:0] cos_q
);

    localparam int  DEPTH = 2 ** LUT_AW;
    localparam real PI    = 3.14159265358979323846;

    logic [PHASE_W-1:0]      r_phase;
    logic signed [AMP_W-1:0] w_rom [DEPTH];
    logic [LUT_AW-1:0]       w_sin_addr;
    logic [LUT_AW-1:0]       w_cos_addr;
    logic                    w_unused_phase;

    function automatic logic signed [AMP_W-1:0] sin_entry(input int k);
        real x;
        x = real'((2 ** (AMP_W - 1)) - 1) * $sin(2.0 * PI * real'(k) / real'(DEPTH));
        if (x >= 0.0) return AMP_W'($rtoi(x + 0.5));
        return AMP_W'(-$rtoi(0.5 - x));
    endfunction

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign w_rom[k] = sin_entry(k);
    end

    // Cosine is the sine a quarter turn ahead; the add wraps in LUT_AW bits.
    assign w_sin_addr     = r_phase[PHASE_W-1 -: LUT_AW];
    assign w_cos_addr     = w_sin_addr + LUT_AW'(DEPTH / 4);
    assign w_unused_phase = ^r_phase;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            if (clear) begin
                r_phase <= '0;
            end else if (advance) begin
                r_phase <= r_phase + PHASE_W'(FCW);
            end
            sin_q <= w_rom[w_sin_addr];
            cos_q <= w_rom[w_cos_addr];
        end
    end

endmodule

// File: rtl/qam_tx_core.sv
// Square M-QAM transmitter: bit collector, symbol mapper, NCO and 3-stage I*cos - Q*sin mixer.
// Define QAM_TX_GRAY_EN to Gray-decode each axis index before level mapping.
module qam_tx_core
    import qam_tx_pkg::*;
#(
    parameter int BPS     = 4,
    parameter int SPS     = 8,
    parameter int PHASE_W = 16,
    parameter int FCW     = 4096,
    parameter int LUT_AW  = 6,
    parameter int AMP_W   = 16,
    parameter int OUT_W   = AMP_W + BPS / 2 + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic                    sym_strobe,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] mixed_output,
    output logic                    underrun,
    output qam_state_e              dbg_state
);

    localparam int H      = BPS / 2;
    localparam int SYM_W  = H + 1;
    localparam int CNT_W  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int FILL_W = $clog2(BPS + 1);
    localparam int PROD_W = AMP_W + SYM_W;

    qam_state_e               r_state;
    logic [BPS-1:0]           r_shift;
    logic [FILL_W-1:0]        r_fill;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [SYM_W-1:0]  r_sym_i, r_sym_q;
    logic                     r_s1_valid, r_s2_valid;
    logic signed [SYM_W-1:0]  r_s1_i, r_s1_q;
    logic signed [PROD_W-1:0] r_p_i, r_p_q;

    logic                     w_full, w_last, w_run, w_stop, w_accept;
    logic [IDX_MAX_W-1:0]     w_bin_i, w_bin_q;
    logic signed [SYM_W-1:0]  w_lvl_i, w_lvl_q;
    logic signed [AMP_W-1:0]  w_sin, w_cos;

    // Handshake: a bit moves on any rising edge where bit_valid && bit_ready; bit_ready never
    // depends on bit_valid, and it stays low while the collector holds a complete symbol.
    assign w_full    = (r_fill == FILL_W'(BPS));
    assign bit_ready = rst && start && !w_full;
    assign w_accept  = bit_valid && bit_ready;
    assign w_last    = (r_cnt == CNT_W'(SPS - 1));
    assign w_run     = (r_state == RUN);
    assign w_stop    = w_run && w_last && !start;
    assign dbg_state = r_state;

`ifdef QAM_TX_GRAY_EN
    assign w_bin_i = gray2bin(IDX_MAX_W'(r_shift[BPS-1 -: H]));
    assign w_bin_q = gray2bin(IDX_MAX_W'(r_shift[H-1:0]));
`else
    assign w_bin_i = IDX_MAX_W'(r_shift[BPS-1 -: H]);
    assign w_bin_q = IDX_MAX_W'(r_shift[H-1:0]);
`endif
    assign w_lvl_i = SYM_W'(idx_to_level(w_bin_i, H));
    assign w_lvl_q = SYM_W'(idx_to_level(w_bin_q, H));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_fill     <= '0;
            r_cnt      <= '0;
            r_sym_i    <= '0;
            r_sym_q    <= '0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sym_strobe <= 1'b0;
            if (w_accept) begin
                r_shift <= {r_shift[BPS-2:0], bit_in};
                r_fill  <= r_fill + FILL_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start && w_full) begin
                        r_sym_i    <= w_lvl_i;
                        r_sym_q    <= w_lvl_q;
                        r_fill     <= '0;
                        sym_strobe <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                    if (w_last) begin
                        if (!start) begin
                            r_state <= IDLE;
                        end else if (w_full) begin
                            r_sym_i    <= w_lvl_i;
                            r_sym_q    <= w_lvl_q;
                            r_fill     <= '0;
                            sym_strobe <= 1'b1;
                        end else begin
                            r_sym_i    <= '0;
                            r_sym_q    <= '0;
                            underrun   <= 1'b1;
                            sym_strobe <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    qam_nco_lut #(
        .PHASE_W(PHASE_W),
        .FCW    (FCW),
        .LUT_AW (LUT_AW),
        .AMP_W  (AMP_W)
    ) u_nco (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_stop),
        .advance(w_run),
        .sin_q  (w_sin),
        .cos_q  (w_cos)
    );

    // Zeroing I/Q outside RUN makes the idle output fall out of the same datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_i       <= '0;
            r_s1_q       <= '0;
            r_s2_valid   <= 1'b0;
            r_p_i        <= '0;
            r_p_q        <= '0;
            out_valid    <= 1'b0;
            mixed_output <= '0;
        end else begin
            r_s1_valid   <= w_run;
            r_s1_i       <= w_run ? r_sym_i : '0;
            r_s1_q       <= w_run ? r_sym_q : '0;
            r_s2_valid   <= r_s1_valid;
            r_p_i        <= PROD_W'(r_s1_i) * PROD_W'(w_cos);
            r_p_q        <= PROD_W'(r_s1_q) * PROD_W'(w_sin);
            out_valid    <= r_s2_valid;
            mixed_output <= OUT_W'(r_p_i) - OUT_W'(r_p_q);
        end
    end

endmodule

// File: doc/qam_tx_core.md
# qam_tx_core

Parametrised square M-QAM transmitter core, the next generation of the fixed 16-QAM chain: one block combining bit collection, symbol mapping, NCO and I/Q mixing. It adds a ready/valid bit interface, a configurable constellation size and samples-per-symbol, underrun detection, and a pipelined, width-generic mixer. It feeds the DAC-side sample path.

## Interface
- BPS, default 4: bits per symbol; even, 2..8 (QPSK..256-QAM).
- SPS, default 8: output samples per symbol; must be ≥ BPS+1.
- PHASE_W, default 16: NCO phase accumulator width.
- FCW, default 4096: phase increment per clock.
- LUT_AW, default 6: sine LUT address width (2^LUT_AW entries, full wave).
- AMP_W, default 16: signed sine/cosine amplitude width.
- OUT_W, default AMP_W+BPS/2+2: mixed output width (20 at defaults).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  transmit enable.
- bit_in  in  1  serial payload bit.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  collector accepts a bit this cycle.
- sym_strobe  out  1  one-cycle pulse when a symbol is loaded or underrun.
- out_valid  out  1  mixed_output is a live sample.
- mixed_output  out  OUT_W  signed I·cos − Q·sin.
- underrun  out  1  sticky: a symbol boundary found the collector not full.

## Operation
- Reset (rst=0): all outputs 0; state IDLE; collector empty; phase 0; sample counter 0; pipeline cleared.
- Collector: BPS-bit shift register plus fill count. A bit transfers on bit_valid && bit_ready. bit_ready = start && fill < BPS. The first bit received is the symbol MSB.
- Mapping: the upper BPS/2 bits give the I index and the lower BPS/2 bits give the Q index. Level = 2k − (L−1), with L = 2^(BPS/2). The level is signed, BPS/2+1 bits wide.
- FSM IDLE: phase held 0, out_valid 0, output 0. When start && fill==BPS: load the symbol, clear fill, pulse sym_strobe, zero the counter, go to RUN.
- FSM RUN: each cycle phase += FCW (mod 2^PHASE_W) and the counter increments. When the counter reaches SPS−1:
  - if start==0: go to IDLE and reset phase to 0;
  - else if fill==BPS: load the next symbol, clear fill, pulse sym_strobe;
  - else: load I=Q=0, set underrun, pulse sym_strobe, and stay in RUN.
  - The counter wraps to 0.
- A load and a bit acceptance never coincide, because a load requires fill==BPS, which forces bit_ready=0. The collector accepts again on the cycle after the load.
- Deasserting start mid-symbol lets the current symbol complete. Collector contents are retained across IDLE.
- LUT: entry k = round((2^(AMP_W−1)−1)·sin(2πk/2^LUT_AW)).
  - sin address = phase[PHASE_W−1 -: LUT_AW].
  - cos address = sin address + 2^(LUT_AW−2), modulo 2^LUT_AW.
- Arithmetic: products are full width; the difference is sign-extended to OUT_W with no saturation. The parameter constraint guarantees no overflow.

## Timing
- Pipeline: S1 registered LUT read; S2 registered I·cos and Q·sin; S3 registered difference.
- The sample for the phase and symbol present in cycle t appears on mixed_output at t+3. out_valid is delayed identically.
- First live sample: 3 cycles after the IDLE→RUN load.
- On RUN→IDLE, out_valid falls 3 cycles after the last RUN cycle, and the output then returns to 0.
- underrun clears only on reset.

## Configuration
- QAM_TX_GRAY_EN defined: each BPS/2-bit index is Gray-decoded to binary before level mapping, so adjacent levels differ by one bit.
- Undefined: natural binary mapping (index "11" → +3 at BPS=4).

## Structure
- Package qam_tx_pkg holds:
  - the FSM state enum (IDLE, RUN);
  - the gray2bin function;
  - the index-to-level function;
  - the derived localparams (L, LVL_W = BPS/2+1).
- Sub-module qam_nco_lut: phase accumulator plus dual-port sine/cos ROM with registered outputs. Parameters PHASE_W, FCW, LUT_AW, AMP_W; inputs clear and advance.

## Test plan
All scenarios use PHASE_W=16, FCW=16384, A=32767.
- Reset: hold rst=0 while start=1 and bit_valid=1 → all outputs 0 and bit_ready 0.
- Natural mapping (no macro), bits 1111: first symbol → samples 98301, −98301, −98301, 98301, repeated twice; sym_strobe at load; first sample 3 cycles after load.
- QAM_TX_GRAY_EN, bits 1111 (I=Q=+1) → samples 32767, −32767, −32767, 32767.
- Underrun: supply one symbol, then stall bit_valid → 8 samples of 0 after the first symbol; underrun=1 and stays set after new data arrives.
- Backpressure: bit_valid held 1 → bit_ready low for exactly the cycles with fill==BPS; no bit lost; the sequence 0001, 0010, 1000 maps (natural) to I/Q (−3,−1), (−3,+1), (+1,−3).
- Stop: start dropped at counter 2 → symbol completes 8 samples; out_valid falls 3 cycles after; a restart begins at phase 0.
